// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read, writeback and issue bundle of the register file
// Signals:
//   ra        NREAD*AW     read addresses, port i at [i*AW +: AW]
//   rd        NREAD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
//   rd_busy   NREAD        pending-write status of each read address
//   we/wa/wd               writeback enable, address, data
//   iss_valid/iss_wa       issue strobe and destination register
//   ready                  high once the post-reset clear has finished
// Modports: master drives addresses/writeback/issue, slave is the register file.
interface regfile_scoreboard_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(DEPTH)
);
    logic [NREAD*AW-1:0]    ra;
    logic [NREAD*WIDTH-1:0] rd;
    logic [NREAD-1:0]       rd_busy;
    logic                   we;
    logic [AW-1:0]          wa;
    logic [WIDTH-1:0]       wd;
    logic                   iss_valid;
    logic [AW-1:0]          iss_wa;
    logic                   ready;
    modport master (output ra, we, wa, wd, iss_valid, iss_wa, input rd, rd_busy, ready);
    modport slave  (input ra, we, wa, wd, iss_valid, iss_wa, output rd, rd_busy, ready);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read-port register file with write bypass, pending-write scoreboard and post-reset clear
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of regfile_scoreboard_if (read ports, writeback, issue, ready)
module regfile_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  bus
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t            r_state, w_state_nxt;
    logic [AW-1:0]     r_idx, w_idx_nxt;
    logic [DEPTH-1:0]  r_busy, w_busy_nxt;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_run, w_wr, w_set;
    assign w_run     = r_state == ST_RUN;
    // Writes and issues to register 0 are dropped when it is hardwired to zero
    assign w_wr      = w_run && bus.we && (ZERO_REG == 0 || bus.wa != '0);
    assign w_set     = w_run && bus.iss_valid && (ZERO_REG == 0 || bus.iss_wa != '0);
    assign bus.ready = w_run;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
            r_busy  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= w_busy_nxt;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_busy_nxt  = r_busy;
        if (!w_run) begin
            w_idx_nxt = r_idx + AW'(1);
            if (r_idx == AW'(DEPTH - 1)) w_state_nxt = ST_RUN;
        end
        // Clear first so that an issue to the retiring register keeps it busy
        if (w_run && bus.we) w_busy_nxt[bus.wa] = 1'b0;
        if (w_set) w_busy_nxt[bus.iss_wa] = 1'b1;
    end
    // Storage has no reset; the sequencer zeroes one entry per cycle instead
    always_ff @(posedge clk) begin
        if (!w_run) r_mem[r_idx] <= '0;
        else if (w_wr) r_mem[bus.wa] <= bus.wd;
    end
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_zero;
        logic          w_byp;
        assign w_ra   = bus.ra[i*AW +: AW];
        assign w_zero = ZERO_REG != 0 && w_ra == '0;
        assign w_byp  = w_wr && bus.wa == w_ra;
        assign bus.rd[i*WIDTH +: WIDTH] = (!w_run || w_zero) ? '0 : w_byp ? bus.wd : r_mem[w_ra];
        // A retiring write to this address makes the operand available now
        assign bus.rd_busy[i] = w_run && !(bus.we && bus.wa == w_ra) && r_busy[w_ra];
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: randomized and directed checks of regfile_scoreboard against a behavioural model
module tb_regfile_scoreboard;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int AW = 5;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [W-1:0] m_mem [D];
    bit           m_busy [D];
    int           m_cnt;
    regfile_scoreboard_if #(.WIDTH(W), .DEPTH(D), .NREAD(NR)) bus ();
    regfile_scoreboard #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic model_clear();
        m_cnt = 0;
        for (int r = 0; r < D; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask
    // Compare all outputs against what the model says for the inputs now on the bus
    task automatic check_outputs();
        int a;
        logic [W-1:0] e_rd;
        bit e_busy;
        bit running;
        running = m_cnt >= D;
        check("ready", bus.ready, running);
        for (int p = 0; p < NR; p++) begin
            a = int'(bus.ra[p*AW +: AW]);
            if (!running || a == 0) e_rd = '0;
            else if (bus.we && int'(bus.wa) == a) e_rd = bus.wd;
            else e_rd = m_mem[a];
            e_busy = running && !(bus.we && int'(bus.wa) == a) && m_busy[a];
            check($sformatf("rd%0d_r%0d", p, a), bus.rd[p*W +: W], e_rd);
            check($sformatf("busy%0d_r%0d", p, a), bus.rd_busy[p], e_busy);
        end
    endtask
    task automatic step(input int a0, input int a1, input bit w, input int adr,
                        input logic [W-1:0] d, input bit iv, input int ia);
        @(negedge clk);
        bus.ra        = {AW'(a1), AW'(a0)};
        bus.we        = w;
        bus.wa        = AW'(adr);
        bus.wd        = d;
        bus.iss_valid = iv;
        bus.iss_wa    = AW'(ia);
        #1;
        check_outputs();
        @(posedge clk);
        if (m_cnt < D) m_cnt++;
        else begin
            if (w && adr != 0) m_mem[adr] = d;
            if (w) m_busy[adr] = 1'b0;
            if (iv && ia != 0) m_busy[ia] = 1'b1;
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_outputs();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask
    initial begin
        bus.ra = '0; bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
        bus.iss_valid = 1'b0; bus.iss_wa = '0;
        model_clear();
        do_reset();
        for (int k = 0; k < D; k++) step(k, D - 1 - k, 0, 0, 0, 0, 0);
        for (int k = 0; k < D / 2; k++) step(2 * k, 2 * k + 1, 0, 0, 0, 0, 0);
        step(5, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        step(5, 0, 0, 0, 0, 0, 0);
        step(0, 5, 1, 0, 32'h1234, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 7);
        step(0, 7, 0, 0, 0, 0, 0);
        step(0, 7, 1, 7, 32'h55, 0, 0);
        step(0, 7, 0, 0, 0, 0, 0);
        step(0, 0, 1, 9, 32'h99, 1, 9);
        step(9, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 9, 32'h999, 1, 3);
        step(3, 9, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4, 32'hAA, 1, 4);
        step(4, 0, 0, 0, 0, 0, 0);
        do_reset();
        for (int k = 0; k < D; k++) step(4, k, k % 3 == 0, 4, 32'hBAD, k % 5 == 0, 4);
        step(4, 9, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2000; k++) begin
            if (k % 700 == 350) do_reset();
            step($urandom_range(D - 1), $urandom_range(D - 1), $urandom_range(1),
                 $urandom_range(D - 1), $urandom, $urandom_range(2) == 0, $urandom_range(D - 1));
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
